// File: rtl/am_ctrl_pkg.sv
// Shared types and widths for the AM carrier sweep controller.
// Optional feature macro: AM_SWEEP_PINGPONG_EN (triangular sweep), used by am_sweep_ctrl.
package am_ctrl_pkg;

    localparam int PHASE_WIDTH = 32;  // phase increment width, matches modulator accumulator
    localparam int DWELL_WIDTH = 16;  // clk_in cycles per frequency step
    localparam int DEEP_WIDTH  = 16;  // modulation depth word

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // Shadow copy of one sweep programming
    typedef struct packed {
        logic [PHASE_WIDTH-1:0] start;
        logic [PHASE_WIDTH-1:0] stop;
        logic [PHASE_WIDTH-1:0] step;
        logic [DWELL_WIDTH-1:0] dwell;
        logic [DEEP_WIDTH-1:0]  deep;
        logic                   loop;
    } sweep_cfg_t;

endpackage

// File: rtl/am_dwell_timer.sv
// Loadable down-counter timing how long each frequency value is held.
// A load of 0 is treated as 1; expire_o is high while the count is 1,
// so a reload on the expiring edge gives exactly D cycles per value.
module am_dwell_timer
    import am_ctrl_pkg::*;
#(
    parameter int WIDTH = DWELL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] dwell_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] load_val;

    // Next count: clear wins, then load, then decrement toward zero
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d    = cnt_q;
        load_val = (dwell_i == '0) ? WIDTH'(1) : dwell_i;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so all registers update together at the edge.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/am_sweep_ctrl.sv
// Carrier NCO sweep sequencer: steps center_fre from start toward stop,
// holding each value for a programmed dwell, and owns module_deep.
// Optional feature macro: AM_SWEEP_PINGPONG_EN selects a triangular
// (up then down) sweep; without it the sweep is sawtooth only.
module am_sweep_ctrl
    import am_ctrl_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   RST_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_start,
    input  logic [PHASE_WIDTH-1:0] cfg_stop,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [DEEP_WIDTH-1:0]  cfg_deep,
    input  logic                   cfg_loop,
    input  logic                   start,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] center_fre,
    output logic [DEEP_WIDTH-1:0]  module_deep,
    output logic                   fre_upd,
    output logic                   busy,
    output logic                   sweep_done
);

    sweep_state_e           state_q, state_d;
    sweep_cfg_t             cfg_q, cfg_in, cfg_eff;
    logic [PHASE_WIDTH-1:0] center_q, fre_next, up_next;
    logic [DEEP_WIDTH-1:0]  deep_q;
    logic                   fre_upd_q;
    logic [PHASE_WIDTH:0]   sum;
    logic                   cfg_hs, launch, adv, sweep_end, expire, at_stop;
`ifdef AM_SWEEP_PINGPONG_EN
    logic                   dir_q, dir_d;    // 0 = up leg, 1 = down leg
    logic [PHASE_WIDTH:0]   diff;
    logic [PHASE_WIDTH-1:0] down_next;
    logic                   at_start;
`endif

    // A config write in the same cycle as start is forwarded to the launch
    assign cfg_hs  = cfg_valid && (state_q == IDLE);
    assign cfg_in  = '{start: cfg_start, stop: cfg_stop, step: cfg_step,
                       dwell: cfg_dwell, deep: cfg_deep, loop: cfg_loop};
    assign cfg_eff = cfg_hs ? cfg_in : cfg_q;
    assign launch  = (state_q == IDLE) && start && !abort;

    // Clamped next values; the extra bit keeps carry/borrow from wrapping
    always_comb begin
        sum     = {1'b0, center_q} + {1'b0, cfg_q.step};
        up_next = (sum >= {1'b0, cfg_q.stop}) ? cfg_q.stop : sum[PHASE_WIDTH-1:0];
        at_stop = (center_q >= cfg_q.stop);
`ifdef AM_SWEEP_PINGPONG_EN
        diff      = {1'b0, center_q} - {1'b0, cfg_q.step};
        down_next = (diff[PHASE_WIDTH] || (diff[PHASE_WIDTH-1:0] < cfg_q.start))
                    ? cfg_q.start : diff[PHASE_WIDTH-1:0];
        at_start  = (center_q <= cfg_q.start);
`endif
    end

    // End-of-dwell decision: advance, turn around, reload, or finish
    always_comb begin
        adv       = 1'b0;
        sweep_end = 1'b0;
        fre_next  = center_q;
`ifdef AM_SWEEP_PINGPONG_EN
        dir_d     = dir_q;
`endif
        if ((state_q == DWELL) && expire && !abort) begin
`ifdef AM_SWEEP_PINGPONG_EN
            if (!dir_q) begin
                if (at_stop && at_start) begin
                    // start >= stop: nothing to sweep, single dwell then end
                    sweep_end = 1'b1;
                    if (cfg_q.loop) begin
                        adv      = 1'b1;
                        fre_next = cfg_q.start;
                    end
                end else if (at_stop) begin
                    dir_d    = 1'b1;
                    adv      = 1'b1;
                    fre_next = down_next;
                end else if (cfg_q.step != '0) begin
                    adv      = 1'b1;
                    fre_next = up_next;
                end
            end else begin
                if (at_start) begin
                    sweep_end = 1'b1;
                    if (cfg_q.loop) begin
                        dir_d    = 1'b0;
                        adv      = 1'b1;
                        fre_next = up_next;
                    end
                end else begin
                    adv      = 1'b1;
                    fre_next = down_next;
                end
            end
`else
            if (at_stop) begin
                sweep_end = 1'b1;
                if (cfg_q.loop) begin
                    adv      = 1'b1;
                    fre_next = cfg_q.start;
                end
            end else if (cfg_q.step != '0) begin
                // A zero step never reaches stop, so start is simply held
                adv      = 1'b1;
                fre_next = up_next;
            end
`endif
        end
    end

    am_dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
        .clk      (clk_in),
        .rst_n    (RST_n),
        .load_i   (launch || adv),
        .clear_i  (abort),
        .dwell_i  (cfg_eff.dwell),
        .expire_o (expire)
    );

    // State register
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = DWELL;
            DWELL:   if (sweep_end && !cfg_q.loop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // State-decoded outputs
    always_comb begin
        cfg_ready  = (state_q == IDLE);
        busy       = (state_q == DWELL);
        sweep_done = (state_q == DONE);
    end

    // Shadow config and modulator controls; depth only changes at launch
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            // NOTE: the shadow config is a handful of flops, not a RAM, so it is reset like any register.
            cfg_q     <= '0;
            center_q  <= '0;
            deep_q    <= '0;
            fre_upd_q <= 1'b0;
`ifdef AM_SWEEP_PINGPONG_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            fre_upd_q <= 1'b0;
            if (cfg_hs) begin
                cfg_q <= cfg_in;
            end
            if (launch) begin
                center_q  <= cfg_eff.start;
                deep_q    <= cfg_eff.deep;
                fre_upd_q <= 1'b1;
            end else if (adv) begin
                center_q  <= fre_next;
                fre_upd_q <= 1'b1;
            end
`ifdef AM_SWEEP_PINGPONG_EN
            if (launch || abort) begin
                dir_q <= 1'b0;
            end else if (adv) begin
                dir_q <= dir_d;
            end
`endif
        end
    end

    assign center_fre  = center_q;
    assign module_deep = deep_q;
    assign fre_upd     = fre_upd_q;

endmodule

// File: tb/tb_am_sweep_ctrl.sv
// Scoreboard bench for am_sweep_ctrl: stimulus pushes expected fre_upd /
// sweep_done events, a negedge monitor pops and compares each one.
// Honours AM_SWEEP_PINGPONG_EN for the triangular-sweep vector.
`timescale 1ns/1ps
module tb_am_sweep_ctrl;

    logic        clk_in    = 1'b0;
    logic        RST_n     = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_stop  = '0;
    logic [31:0] cfg_step  = '0;
    logic [15:0] cfg_dwell = '0;
    logic [15:0] cfg_deep  = '0;
    logic        cfg_loop  = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic [31:0] center_fre;
    logic [15:0] module_deep;
    logic        fre_upd;
    logic        busy;
    logic        sweep_done;

    typedef struct {
        bit          is_done;
        logic [31:0] fre;
        logic [15:0] deep;
        int          gap;     // cycles since previous event, 0 = not checked
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_evt = 0;
    int   busy_cycles = 0;

    am_sweep_ctrl dut (
        .clk_in      (clk_in),
        .RST_n       (RST_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_deep    (cfg_deep),
        .cfg_loop    (cfg_loop),
        .start       (start),
        .abort       (abort),
        .center_fre  (center_fre),
        .module_deep (module_deep),
        .fre_upd     (fre_upd),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented event against the scoreboard head
    always @(negedge clk_in) begin
        exp_t e;
        cyc++;
        if (RST_n && busy) busy_cycles++;
        if (RST_n && (fre_upd || sweep_done)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: fre_upd=%0b sweep_done=%0b center_fre=0x%0h, none expected",
                         fre_upd, sweep_done, center_fre);
            end else begin
                e = sb_q.pop_front();
                check("evt_kind", {63'd0, sweep_done}, {63'd0, e.is_done});
                check("evt_center", center_fre, e.fre);
                if (!e.is_done) check("evt_deep", module_deep, e.deep);
                if (e.gap != 0) check("evt_gap", cyc - last_evt, e.gap);
            end
            last_evt = cyc;
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic push_upd(input logic [31:0] f, input logic [15:0] d, input int gap);
        exp_t e;
        e.is_done = 1'b0; e.fre = f; e.deep = d; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] f, input int gap);
        exp_t e;
        e.is_done = 1'b1; e.fre = f; e.deep = '0; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic drive_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] dw, input logic [15:0] dp, input logic lp,
                             input logic go);
        tick();
        cfg_valid = 1'b1; cfg_start = s; cfg_stop = e; cfg_step = st;
        cfg_dwell = dw; cfg_deep = dp; cfg_loop = lp; start = go;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
    endtask

    // Wait (bounded) for all expected events, then settle a few cycles
    task automatic drain(input string name, input int budget, input int settle);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sb_q.size(), 0);
        sb_q.delete();
        repeat (settle) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d events pending", sb_q.size());
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int b0;
        // Reset values
        #3;
        check("rst_center", center_fre, 32'd0);
        check("rst_deep", module_deep, 16'd0);
        check("rst_fre_upd", fre_upd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", sweep_done, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        tick(); tick();
        RST_n = 1'b1;
        tick();

        // Basic sawtooth, dwell 3
        b0 = busy_cycles;
        push_upd(32'd100, 16'h8000, 0);
        push_upd(32'd110, 16'h8000, 3);
        push_upd(32'd120, 16'h8000, 3);
        push_upd(32'd130, 16'h8000, 3);
        push_done(32'd130, 3);
        drive_cfg(32'd100, 32'd130, 32'd10, 16'd3, 16'h8000, 1'b0, 1'b0);
        pulse_start();
        drain("t1_drain", 100, 3);
        check("t1_busy_cycles", busy_cycles - b0, 12);
        check("t1_center_held", center_fre, 32'd130);
        check("t1_cfg_ready", cfg_ready, 1'b1);

        // Clamp at stop, dwell 1
        push_upd(32'd100, 16'h0100, 0);
        push_upd(32'd110, 16'h0100, 1);
        push_upd(32'd120, 16'h0100, 1);
        push_upd(32'd125, 16'h0100, 1);
        push_done(32'd125, 1);
        drive_cfg(32'd100, 32'd125, 32'd10, 16'd1, 16'h0100, 1'b0, 1'b0);
        pulse_start();
        drain("t2_drain", 100, 3);

        // Carry clamp near full scale, dwell 0 treated as 1
        push_upd(32'hFFFF_FF00, 16'h0200, 0);
        push_upd(32'hFFFF_FF80, 16'h0200, 1);
        push_upd(32'hFFFF_FFFF, 16'h0200, 1);
        push_done(32'hFFFF_FFFF, 1);
        drive_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 16'h0200, 1'b0, 1'b0);
        pulse_start();
        drain("t3_drain", 100, 3);

        // Continuous sweep, abort while holding the second 10
        push_upd(32'd0, 16'h0300, 0);
        push_upd(32'd10, 16'h0300, 2);
        push_upd(32'd20, 16'h0300, 2);
        push_upd(32'd0, 16'h0300, 2);
        push_upd(32'd10, 16'h0300, 2);
        drive_cfg(32'd0, 32'd20, 32'd10, 16'd2, 16'h0300, 1'b1, 1'b0);
        pulse_start();
        drain("t4_drain", 100, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (10) tick();
        check("t4_abort_center", center_fre, 32'd10);
        check("t4_abort_busy", busy, 1'b0);
        check("t4_abort_ready", cfg_ready, 1'b1);

        // Zero step with forwarded config: start held until abort
        drive_cfg(32'd500, 32'd1000, 32'd5, 16'd2, 16'h1111, 1'b0, 1'b0);
        push_upd(32'd777, 16'h1234, 0);
        drive_cfg(32'd777, 32'd1000, 32'd0, 16'd2, 16'h1234, 1'b0, 1'b1);
        drain("t5_drain", 50, 0);
        b0 = busy_cycles;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 100) begin
                cfg_valid = 1'b1; cfg_start = 32'd42; cfg_step = 32'd1; cfg_deep = 16'h4242;
                check("t5_cfg_ready_low", cfg_ready, 1'b0);
            end
            if (i == 101) cfg_valid = 1'b0;
            if (i == 200) start = 1'b1;
            if (i == 201) start = 1'b0;
        end
        check("t5_busy_cycles", busy_cycles - b0, 1000);
        check("t5_center_held", center_fre, 32'd777);
        pulse_abort();
        tick();
        check("t5_abort_busy", busy, 1'b0);
        // Relaunch without config: the ignored write must not have landed
        push_upd(32'd777, 16'h1234, 0);
        pulse_start();
        drain("t5_relaunch", 50, 0);
        pulse_abort();
        repeat (2) tick();

        // Ping-pong / sawtooth turn-around
        push_upd(32'd0, 16'h00FF, 0);
        push_upd(32'd10, 16'h00FF, 1);
        push_upd(32'd20, 16'h00FF, 1);
        push_upd(32'd30, 16'h00FF, 1);
`ifdef AM_SWEEP_PINGPONG_EN
        push_upd(32'd20, 16'h00FF, 1);
        push_upd(32'd10, 16'h00FF, 1);
        push_upd(32'd0, 16'h00FF, 1);
        push_done(32'd0, 1);
`else
        push_done(32'd30, 1);
`endif
        drive_cfg(32'd0, 32'd30, 32'd10, 16'd1, 16'h00FF, 1'b0, 1'b0);
        pulse_start();
        drain("t6_drain", 100, 3);

        // Asynchronous reset in the middle of a dwell
        push_upd(32'd1000, 16'hABCD, 0);
        drive_cfg(32'd1000, 32'd5000, 32'd100, 16'd5, 16'hABCD, 1'b1, 1'b1);
        drain("t7_launch", 50, 0);
        #2;
        RST_n = 1'b0;
        #1;
        check("t7_rst_center", center_fre, 32'd0);
        check("t7_rst_deep", module_deep, 16'd0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_fre_upd", fre_upd, 1'b0);
        check("t7_rst_cfg_ready", cfg_ready, 1'b1);
        tick();
        sb_q.delete();
        RST_n = 1'b1;
        repeat (5) tick();
        check("t7_idle_after_rst", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
